// File: rtl/mem_ctrl.sv
// Data-side memory controller: serialises byte/half/word loads and stores onto an 8-bit synchronous RAM port.
// Optional build macro MEMCTRL_IO_STALL_EN adds io_buffer_full, which holds off stores to the I/O region.
module mem_ctrl #(
  parameter int              ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic              wr_mem,
  input  logic [31:0]       data_mem,
  input  logic [1:0]        cnf_mem,
  output logic              addr_needed,
  output logic              mem_working,
  output logic              mem_available,
  output logic [31:0]       data_in,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
`ifdef MEMCTRL_IO_STALL_EN
  input  logic              io_buffer_full,
`endif
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       rbuf_q, rbuf_d;
  logic [31:0]       data_in_q, data_in_d;
  logic              io_full;
  logic              stall;

`ifdef MEMCTRL_IO_STALL_EN
  assign io_full = io_buffer_full;
`else
  assign io_full = 1'b0;
`endif

  assign stall = io_full && (ram_a_q >= IO_BASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q       <= '0;
      n_q       <= '0;
      ram_a_q   <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      data_in_q <= '0;
    end else begin
      k_q       <= k_d;
      n_q       <= n_d;
      ram_a_q   <= ram_a_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      data_in_q <= data_in_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    n_d       = n_q;
    ram_a_d   = ram_a_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    data_in_d = data_in_q;
    case (state_q)
      IDLE: begin
        if (cnf_mem != 2'd0) begin
          ram_a_d = addr_mem;
          wdata_d = data_mem;
          rbuf_d  = '0;
          k_d     = 3'd0;
          n_d     = (cnf_mem == 2'd1) ? 3'd1 : (cnf_mem == 2'd2) ? 3'd2 : 3'd4;
          state_d = wr_mem ? WRITE : READ;
        end
      end
      READ: begin
        // ram_din reflects the address issued one cycle earlier, i.e. byte k-1.
        if (k_q == n_q) begin
          case (n_q)
            3'd1:    data_in_d = {24'h0, ram_din};
            3'd2:    data_in_d = {16'h0, ram_din, rbuf_q[7:0]};
            default: data_in_d = {ram_din, rbuf_q};
          endcase
          state_d = DONE;
        end else begin
          case (k_q)
            3'd1:    rbuf_d[7:0]   = ram_din;
            3'd2:    rbuf_d[15:8]  = ram_din;
            3'd3:    rbuf_d[23:16] = ram_din;
            default: ;
          endcase
          k_d = k_q + 3'd1;
          if ((k_q + 3'd1) < n_q) ram_a_d = ram_a_q + ADDR_W'(1);
        end
      end
      WRITE: begin
        if (!stall) begin
          if (k_q == (n_q - 3'd1)) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 3'd1;
            ram_a_d = ram_a_q + ADDR_W'(1);
            wdata_d = {8'h00, wdata_q[31:8]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_needed   = (state_q == IDLE);
  assign mem_working   = (state_q == READ) || (state_q == WRITE);
  assign mem_available = (state_q == DONE);
  assign ram_wr        = (state_q == WRITE) && !stall;
  assign ram_a         = ram_a_q;
  assign ram_dout      = wdata_q[7:0];
  assign data_in       = data_in_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed cases plus randomized loads/stores against a byte-array reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_mem = '0;
  logic        wr_mem = 1'b0;
  logic [31:0] data_mem = '0;
  logic [1:0]  cnf_mem = 2'd0;
  logic        addr_needed, mem_working, mem_available, ram_wr;
  logic [31:0] data_in, ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
`ifdef MEMCTRL_IO_STALL_EN
  logic        io_full = 1'b0;
`endif

  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic        fill = 1'b1;
  logic [31:0] last_load = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .addr_mem(addr_mem), .wr_mem(wr_mem), .data_mem(data_mem),
    .cnf_mem(cnf_mem), .addr_needed(addr_needed), .mem_working(mem_working),
    .mem_available(mem_available), .data_in(data_in), .ram_a(ram_a), .ram_wr(ram_wr),
    .ram_dout(ram_dout),
`ifdef MEMCTRL_IO_STALL_EN
    .io_buffer_full(io_full),
`endif
    .ram_din(ram_din)
  );

  function automatic logic [7:0] seed_byte(int i);
    return 8'((i * 37) ^ (i >> 3) ^ 8'h5A);
  endfunction

  // Synchronous RAM, aliased on the low 12 address bits.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 4096; i++) mem[i] <= seed_byte(i);
    end else if (ram_wr) begin
      mem[ram_a[11:0]] <= ram_dout;
    end
    ram_din <= mem[ram_a[11:0]];
  end

  function automatic logic [31:0] ctl();
    return {28'h0, ram_wr, mem_working, mem_available, addr_needed};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_ctl", ctl(), 32'b0001);
    end
  endtask

  // Presents a request; if the controller is in DONE the request must wait for IDLE.
  // Returns in the DONE cycle of the transaction with cnf_mem already cleared.
  task automatic txn(input logic wr, input logic [1:0] cnf, input logic [31:0] a, input logic [31:0] d);
    int          n;
    logic [31:0] exp;
    logic [31:0] ba;
    n = (cnf == 2'd1) ? 1 : (cnf == 2'd2) ? 2 : 4;
    addr_mem = a; wr_mem = wr; data_mem = d; cnf_mem = cnf;
    if (!addr_needed) begin
      tick();
      check("held_req_idle", ctl(), 32'b0001);
    end
    check("accept_ready", 32'(addr_needed), 32'd1);
    tick();
    cnf_mem = 2'd0; addr_mem = $urandom; data_mem = $urandom; wr_mem = 1'($urandom);
    if (wr) begin
      for (int c = 0; c < n; c++) begin
        check("st_ctl", ctl(), 32'b1100);
        check("st_addr", ram_a, a + 32'(c));
        check("st_byte", 32'(ram_dout), 32'(d[8*c +: 8]));
        ba = a + 32'(c);
        ref_mem[ba[11:0]] = d[8*c +: 8];
        tick();
      end
      check("st_done", ctl(), 32'b0010);
      check("st_keep", data_in, last_load);
    end else begin
      exp = '0;
      for (int c = 0; c < n; c++) begin
        ba = a + 32'(c);
        exp[8*c +: 8] = ref_mem[ba[11:0]];
      end
      for (int c = 0; c <= n; c++) begin
        check("ld_ctl", ctl(), 32'b0100);
        check("ld_addr", ram_a, a + 32'((c < n) ? c : n - 1));
        tick();
      end
      check("ld_done", ctl(), 32'b0010);
      check("ld_data", data_in, exp);
      last_load = exp;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  cnf;
    for (int i = 0; i < 4096; i++) ref_mem[i] = seed_byte(i);
    tick();
    fill = 1'b0;
    tick();
    check("rst_ctl", ctl(), 32'b0001);
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_dout", 32'(ram_dout), 32'h0);
    check("rst_data_in", data_in, 32'h0);
    rst = 1'b0;
    idle_cycles(4);

    // Preload 11/22/33/44 then LW.
    txn(1'b1, 2'd3, 32'h100, 32'h44332211);
    idle_cycles(1);
    txn(1'b0, 2'd3, 32'h100, 32'h0);
    check("lw_value", data_in, 32'h44332211);
    idle_cycles(1);

    txn(1'b1, 2'd1, 32'h203, 32'hDEADBEEF);
    check("sb_data_in_kept", data_in, 32'h44332211);
    idle_cycles(1);

    txn(1'b1, 2'd2, 32'h1FF, 32'h0000A5C3);
    txn(1'b0, 2'd2, 32'h1FF, 32'h0);
    check("lh_value", data_in, 32'h0000A5C3);
    idle_cycles(1);

    // SW aborted by reset during its third byte.
    addr_mem = 32'h300; wr_mem = 1'b1; data_mem = 32'h87654321; cnf_mem = 2'd3;
    tick();
    cnf_mem = 2'd0;
    tick();
    tick();
    check("sw3_wr", 32'(ram_wr), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ctl", ctl(), 32'b0001);
    check("arst_ram_a", ram_a, 32'h0);
    check("arst_dout", 32'(ram_dout), 32'h0);
    check("arst_data_in", data_in, 32'h0);
    ref_mem[12'h300] = 8'h21;
    ref_mem[12'h301] = 8'h43;
    last_load = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_ctl", ctl(), 32'b0001);
    idle_cycles(5);
    txn(1'b0, 2'd3, 32'h300, 32'h0);
    idle_cycles(1);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        default: a = 32'h400 + 32'($urandom_range(0, 63));
      endcase
      cnf = 2'($urandom_range(1, 3));
      txn(1'($urandom), cnf, a, $urandom);
      if ($urandom_range(0, 2) != 0) idle_cycles(1 + $urandom_range(0, 2));
    end

`ifdef MEMCTRL_IO_STALL_EN
    idle_cycles(1);
    addr_mem = 32'h30000; wr_mem = 1'b1; data_mem = 32'h000000C7; cnf_mem = 2'd1;
    io_full = 1'b1;
    tick();
    cnf_mem = 2'd0;
    for (int c = 0; c < 3; c++) begin
      check("io_stall_ctl", ctl(), 32'b0100);
      tick();
    end
    io_full = 1'b0;
    #1;
    check("io_issue_ctl", ctl(), 32'b1100);
    check("io_issue_addr", ram_a, 32'h30000);
    check("io_issue_byte", 32'(ram_dout), 32'hC7);
    ref_mem[12'h000] = 8'hC7;
    tick();
    check("io_done_ctl", ctl(), 32'b0010);
    txn(1'b0, 2'd1, 32'h30000, 32'h0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
